branch_resolve_unit: RTL and testbench

- Back end of the branch-prediction loop: the 2-bit predictor issues predictions, and this block consumes the actual outcomes.
- Holds in-flight predictions in an in-order queue and compares each against the executed branch outcome.
- Raises mispredict/redirect to fetch and drives the training update (pc, actual taken) back to the predictor.
- Sits between fetch/predict and the execute-stage branch comparator.

---
 rtl/bru_pkg.sv | 19 +
 rtl/bru_fifo.sv | 55 +++++
 rtl/branch_resolve_unit.sv | 89 ++++++++
 tb/tb_branch_resolve_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/bru_pkg.sv
// Shared types and helpers for the branch resolve unit.
// The entry PC/target width is fixed here and must match the PC_W parameter of the top.
package bru_pkg;

  localparam int BRU_PC_W   = 32;
  localparam int INSN_BYTES = 4;

  typedef struct packed {
    logic [BRU_PC_W-1:0] pc;
    logic [BRU_PC_W-1:0] target;
    logic                taken;
  } pred_entry_t;

  // The predicted target only matters when both prediction and outcome are taken.
  function automatic logic is_mispredict(pred_entry_t e, logic taken, logic [BRU_PC_W-1:0] target);
    return (e.taken != taken) || (e.taken && taken && (e.target != target));
  endfunction

endpackage

// File: rtl/bru_fifo.sv
// In-order circular queue of in-flight predictions with push, pop and flush.
// A flush clears the whole queue and wins over a same-cycle push.
module bru_fifo
  import bru_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  pred_entry_t              wdata,
  output pred_entry_t              head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  pred_entry_t     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt;
  logic            do_push, do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Compares queued branch predictions against executed outcomes, redirects fetch on a miss
// and trains the predictor. Define BRU_STATS_EN to add saturating branch/mispredict counters.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int PC_W  = BRU_PC_W,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pred_valid,
  output logic                     pred_ready,
  input  logic                     pred_taken,
  input  logic [PC_W-1:0]          pred_pc,
  input  logic [PC_W-1:0]          pred_target,
  input  logic                     res_valid,
  input  logic                     res_taken,
  input  logic [PC_W-1:0]          res_target,
  output logic                     mispredict,
  output logic [PC_W-1:0]          redirect_pc,
  output logic                     upd_valid,
  output logic [PC_W-1:0]          upd_pc,
  output logic                     upd_taken,
  output logic                     res_error,
`ifdef BRU_STATS_EN
  output logic [CNT_W-1:0]         branch_cnt,
  output logic [CNT_W-1:0]         mispred_cnt,
`endif
  output logic [$clog2(DEPTH):0]   occupancy
);

  pred_entry_t head, wdata;
  logic        full, empty;
  logic        do_push, do_pop, miss;

  // pred_ready comes from the registered count, so a full queue never takes a push.
  assign pred_ready = !full;
  assign do_push    = pred_valid && pred_ready;
  assign do_pop     = res_valid && !empty;
  assign miss       = do_pop && is_mispredict(head, res_taken, res_target);
  assign wdata      = '{pc: pred_pc, target: pred_target, taken: pred_taken};

  bru_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (do_push),
    .pop   (do_pop),
    .flush (miss),
    .wdata (wdata),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (occupancy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict  <= 1'b0;
      redirect_pc <= '0;
      upd_valid   <= 1'b0;
      upd_pc      <= '0;
      upd_taken   <= 1'b0;
      res_error   <= 1'b0;
    end else begin
      upd_valid  <= do_pop;
      mispredict <= miss;
      if (do_pop) begin
        upd_pc    <= head.pc;
        upd_taken <= res_taken;
      end
      if (miss) redirect_pc <= res_taken ? res_target : head.pc + PC_W'(INSN_BYTES);
      if (res_valid && empty) res_error <= 1'b1;
    end
  end

`ifdef BRU_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (do_pop && (branch_cnt != '1)) branch_cnt  <= branch_cnt + CNT_W'(1);
      if (miss && (mispred_cnt != '1))  mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with hand-computed expectations.
module tb_branch_resolve_unit;

  localparam int PC_W  = 32;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              pred_valid, pred_ready, pred_taken;
  logic [PC_W-1:0]   pred_pc, pred_target;
  logic              res_valid, res_taken;
  logic [PC_W-1:0]   res_target;
  logic              mispredict, upd_valid, upd_taken, res_error;
  logic [PC_W-1:0]   redirect_pc, upd_pc;
  logic [2:0]        occupancy;
`ifdef BRU_STATS_EN
  logic [15:0]       branch_cnt, mispred_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .pred_valid  (pred_valid),
    .pred_ready  (pred_ready),
    .pred_taken  (pred_taken),
    .pred_pc     (pred_pc),
    .pred_target (pred_target),
    .res_valid   (res_valid),
    .res_taken   (res_taken),
    .res_target  (res_target),
    .mispredict  (mispredict),
    .redirect_pc (redirect_pc),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .res_error   (res_error),
`ifdef BRU_STATS_EN
    .branch_cnt  (branch_cnt),
    .mispred_cnt (mispred_cnt),
`endif
    .occupancy   (occupancy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; everything is driven and sampled 1 time unit after posedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic v, input logic [PC_W-1:0] pc, input logic tk, input logic [PC_W-1:0] tg);
    pred_valid = v; pred_pc = pc; pred_taken = tk; pred_target = tg;
  endtask

  task automatic set_res(input logic v, input logic tk, input logic [PC_W-1:0] tg);
    res_valid = v; res_taken = tk; res_target = tg;
  endtask

  task automatic idle();
    set_push(1'b0, '0, 1'b0, '0);
    set_res(1'b0, 1'b0, '0);
  endtask

  task automatic push_one(input logic [PC_W-1:0] pc, input logic tk, input logic [PC_W-1:0] tg);
    set_push(1'b1, pc, tk, tg);
    step();
    idle();
  endtask

  task automatic resolve(input logic tk, input logic [PC_W-1:0] tg);
    set_res(1'b1, tk, tg);
    step();
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;

    chk("rst_occ", occupancy, 0);
    chk("rst_ready", pred_ready, 1);
    chk("rst_misp", mispredict, 0);
    chk("rst_upd", upd_valid, 0);
    chk("rst_err", res_error, 0);
    chk("rst_redir", redirect_pc, 0);
    chk("rst_updpc", upd_pc, 0);

    // correct taken prediction
    push_one(32'h100, 1'b1, 32'h200);
    chk("t1_occ_push", occupancy, 1);
    resolve(1'b1, 32'h200);
    chk("t1_upd_valid", upd_valid, 1);
    chk("t1_upd_pc", upd_pc, 32'h100);
    chk("t1_upd_taken", upd_taken, 1);
    chk("t1_misp", mispredict, 0);
    chk("t1_occ", occupancy, 0);
    step();
    chk("t1_upd_pulse", upd_valid, 0);

    // predicted not-taken, actually taken
    push_one(32'h100, 1'b0, 32'h0);
    resolve(1'b1, 32'h180);
    chk("t2_misp", mispredict, 1);
    chk("t2_redir", redirect_pc, 32'h180);
    chk("t2_occ", occupancy, 0);
    chk("t2_upd_valid", upd_valid, 1);
    step();
    chk("t2_misp_pulse", mispredict, 0);

    // taken/taken but target mismatch
    push_one(32'h100, 1'b1, 32'h200);
    resolve(1'b1, 32'h240);
    chk("t3_misp", mispredict, 1);
    chk("t3_redir", redirect_pc, 32'h240);

    // predicted taken, actually not taken -> fall-through pc+4
    push_one(32'h100, 1'b1, 32'h200);
    resolve(1'b0, 32'h0);
    chk("t4_misp", mispredict, 1);
    chk("t4_redir", redirect_pc, 32'h104);
    chk("t4_upd_taken", upd_taken, 0);
    push_one(32'hFFFF_FFFC, 1'b1, 32'h200);
    resolve(1'b0, 32'h0);
    chk("t4_wrap_misp", mispredict, 1);
    chk("t4_wrap_redir", redirect_pc, 32'h0);

    // fill the queue
    push_one(32'h0, 1'b0, 32'h0);
    push_one(32'h4, 1'b0, 32'h0);
    push_one(32'h8, 1'b0, 32'h0);
    push_one(32'hC, 1'b0, 32'h0);
    chk("t5_occ_full", occupancy, 4);
    chk("t5_ready_full", pred_ready, 0);
    push_one(32'h10, 1'b0, 32'h0);
    chk("t5_occ_5th", occupancy, 4);

    // push while full is ignored, pop still happens
    set_push(1'b1, 32'h10, 1'b0, 32'h0);
    set_res(1'b1, 1'b0, 32'h0);
    step();
    idle();
    chk("t5_full_pop_occ", occupancy, 3);
    chk("t5_full_pop_pc", upd_pc, 32'h0);
    chk("t5_ready_3", pred_ready, 1);

    // push + correct pop with room: occupancy unchanged
    set_push(1'b1, 32'h10, 1'b0, 32'h0);
    set_res(1'b1, 1'b0, 32'h0);
    step();
    idle();
    chk("t5_pushpop_occ", occupancy, 3);
    chk("t5_pushpop_pc", upd_pc, 32'h4);
    chk("t5_pushpop_misp", mispredict, 0);

    // mispredict at pc 0x8 while pushing: everything flushed, push dropped
    set_push(1'b1, 32'h14, 1'b0, 32'h0);
    set_res(1'b1, 1'b1, 32'h300);
    step();
    idle();
    chk("t5_flush_misp", mispredict, 1);
    chk("t5_flush_pc", upd_pc, 32'h8);
    chk("t5_flush_redir", redirect_pc, 32'h300);
    chk("t5_flush_occ", occupancy, 0);
    push_one(32'h20, 1'b0, 32'h0);
    chk("t5_after_occ", occupancy, 1);
    resolve(1'b0, 32'h0);
    chk("t5_after_pc", upd_pc, 32'h20);
    chk("t5_after_misp", mispredict, 0);

    // resolve with empty queue
    resolve(1'b1, 32'h400);
    chk("t6_err", res_error, 1);
    chk("t6_no_upd", upd_valid, 0);
    chk("t6_no_misp", mispredict, 0);
    step();
    chk("t6_err_sticky", res_error, 1);

    // reset mid-stream with 3 entries, alongside a would-be mispredict
    push_one(32'h40, 1'b1, 32'h80);
    push_one(32'h44, 1'b0, 32'h0);
    push_one(32'h48, 1'b0, 32'h0);
    chk("t7_occ3", occupancy, 3);
    rst = 1'b1;
    set_res(1'b1, 1'b0, 32'h0);
    step();
    rst = 1'b0;
    idle();
    chk("t7_occ", occupancy, 0);
    chk("t7_err", res_error, 0);
    chk("t7_misp", mispredict, 0);
    chk("t7_upd", upd_valid, 0);
    chk("t7_redir", redirect_pc, 0);
    chk("t7_updpc", upd_pc, 0);
    chk("t7_ready", pred_ready, 1);
    // entries from before reset must be gone
    resolve(1'b0, 32'h0);
    chk("t7_empty_err", res_error, 1);
    chk("t7_empty_upd", upd_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
